// File: rtl/pb_debouncer.sv
// pb_debouncer: synchronizes a raw asynchronous pushbutton and debounces it.
// A SYNC_STAGES flop chain removes metastability. A four-state FSM then
// accepts a new level only after DEBOUNCE_CYCLES consecutive identical
// synchronized samples. Any opposite sample during qualification restarts it.
// Optional feature macro: PB_GLITCH_CNT_EN adds an 8-bit saturating count of
// rejected glitches on the glitchCount port.

module pb_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pbIn,
    output logic       pbOut
`ifdef PB_GLITCH_CNT_EN
    ,
    output logic [7:0] glitchCount
`endif
);

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10,
        S_FALL = 2'b11
    } state_t;

    // The count value on which the qualifying sample completes a transition.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   pb_sync_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_nxt_s;
    logic                   out_nxt_s;
    logic                   reject_s;

    // Synchronizer chain: bit 0 samples the raw button, the last bit is pb_sync_s.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pbIn};
        end
    end

    assign pb_sync_s = sync_r[SYNC_STAGES-1];

    // FSM state, stability counter and debounced output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_LOW;
            cnt_r   <= '0;
            pbOut   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pbOut   <= out_nxt_s;
        end
    end

    // Next-state logic: qualify a new level, reject anything shorter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        out_nxt_s   = pbOut;
        reject_s    = 1'b0;
        case (state_r)
            S_LOW: begin
                if (pb_sync_s) begin
                    state_nxt_s = S_RISE;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            S_RISE: begin
                if (!pb_sync_s) begin
                    state_nxt_s = S_LOW;
                    cnt_nxt_s   = '0;
                    reject_s    = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_HIGH;
                    cnt_nxt_s   = '0;
                    out_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!pb_sync_s) begin
                    state_nxt_s = S_FALL;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            S_FALL: begin
                if (pb_sync_s) begin
                    state_nxt_s = S_HIGH;
                    cnt_nxt_s   = '0;
                    reject_s    = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = S_LOW;
                    cnt_nxt_s   = '0;
                    out_nxt_s   = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = S_LOW;
                cnt_nxt_s   = '0;
                out_nxt_s   = 1'b0;
            end
        endcase
    end

`ifdef PB_GLITCH_CNT_EN
    logic [7:0] glitch_r;

    // Saturating count of rejected glitches, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            glitch_r <= 8'h00;
        end else if (reject_s && (glitch_r != 8'hFF)) begin
            glitch_r <= glitch_r + 8'h01;
        end else begin
            glitch_r <= glitch_r;
        end
    end

    assign glitchCount = glitch_r;
`else
    // Rejection strobe only feeds the optional glitch counter.
    logic unused_s;
    assign unused_s = reject_s;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed bench for pb_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A run-length model predicts pbOut (and glitchCount when PB_GLITCH_CNT_EN
// is defined) every cycle; hand-computed literals pin key moments.

module tb_pb_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clock;
    logic reset;
    logic pbIn;
    logic pbOut;
`ifdef PB_GLITCH_CNT_EN
    logic [7:0] glitchCount;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic cmp_en = 1'b0;

    pb_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pbIn       (pbIn),
        .pbOut      (pbOut)
`ifdef PB_GLITCH_CNT_EN
        ,
        .glitchCount(glitchCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: delay line for the synchronizer, then a run length of samples
    // that disagree with the current output; DEB in a row flips the output,
    // an agreeing sample after a non-zero run is a rejected glitch.
    logic [SYNC-1:0] m_hist;
    logic            m_out;
    int              m_run;
    int              m_glitch;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_hist   <= '0;
            m_out    <= 1'b0;
            m_run    <= 0;
            m_glitch <= 0;
        end else begin
            m_hist <= {m_hist[SYNC-2:0], pbIn};
            if (m_hist[SYNC-1] != m_out) begin
                if (m_run + 1 == DEB) begin
                    m_out <= m_hist[SYNC-1];
                    m_run <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run != 0 && m_glitch < 255) m_glitch <= m_glitch + 1;
                m_run <= 0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            n_total++;
            if (pbOut !== m_out) $display("FAIL model_pbOut @%0t: got %b, expected %b", $time, pbOut, m_out);
            else n_pass++;
`ifdef PB_GLITCH_CNT_EN
            n_total++;
            if (glitchCount !== m_glitch[7:0])
                $display("FAIL model_glitch @%0t: got %0d, expected %0d", $time, glitchCount, m_glitch);
            else n_pass++;
`endif
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Advance n posedges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pbIn  = 1'b0;
        step(2);
        reset = 1'b1;
        step(3);
    endtask

    initial begin
        reset = 1'b0;
        pbIn  = 1'b1;
        #1 cmp_en = 1'b1;

        // 1: button held through reset, then released from reset
        step(5);
        chk("t1_in_reset", {7'd0, pbOut}, 8'd0);
        reset = 1'b1;
        step(5);
        chk("t1_edge5", {7'd0, pbOut}, 8'd0);
        step(1);
        chk("t1_edge6", {7'd0, pbOut}, 8'd1);

        // 2: clean release and clean press, both 6 edges
        pbIn = 1'b0;
        step(5);
        chk("t2_rel_edge5", {7'd0, pbOut}, 8'd1);
        step(1);
        chk("t2_rel_edge6", {7'd0, pbOut}, 8'd0);
        step(3);
        pbIn = 1'b1;
        step(5);
        chk("t2_press_edge5", {7'd0, pbOut}, 8'd0);
        step(1);
        chk("t2_press_edge6", {7'd0, pbOut}, 8'd1);
        // async reset while high clears the output with no clock edge
        reset = 1'b0;
        #1;
        chk("t2_async_clear", {7'd0, pbOut}, 8'd0);
        do_reset();

        // 3: 3-clock glitch rejected
        pbIn = 1'b1;
        step(3);
        pbIn = 1'b0;
        step(8);
        chk("t3_glitch_out", {7'd0, pbOut}, 8'd0);
`ifdef PB_GLITCH_CNT_EN
        chk("t3_glitch_cnt", glitchCount, 8'd1);
`endif

        // 4: bounce 1,0,1,0 then held 1
        do_reset();
        pbIn = 1'b1; step(1);
        pbIn = 1'b0; step(1);
        pbIn = 1'b1; step(1);
        pbIn = 1'b0; step(1);
        pbIn = 1'b1;
        step(5);
        chk("t4_edge5", {7'd0, pbOut}, 8'd0);
        step(1);
        chk("t4_edge6", {7'd0, pbOut}, 8'd1);
`ifdef PB_GLITCH_CNT_EN
        chk("t4_glitch_cnt", glitchCount, 8'd2);
`endif

        // 5: reset pulse while qualifying a press (cnt=2)
        pbIn = 1'b0;
        step(10);
        chk("t5_low_before", {7'd0, pbOut}, 8'd0);
        pbIn = 1'b1;
        step(4);
        reset = 1'b0;
        #1;
        chk("t5_async_out", {7'd0, pbOut}, 8'd0);
        step(2);
        reset = 1'b1;
        step(5);
        chk("t5_edge5", {7'd0, pbOut}, 8'd0);
        step(1);
        chk("t5_edge6", {7'd0, pbOut}, 8'd1);

        // 6: 300 rejected 2-clock glitches saturate the counter
        do_reset();
        for (int i = 0; i < 300; i++) begin
            pbIn = 1'b1; step(2);
            pbIn = 1'b0; step(2);
        end
        step(4);
        chk("t6_out", {7'd0, pbOut}, 8'd0);
`ifdef PB_GLITCH_CNT_EN
        chk("t6_glitch_sat", glitchCount, 8'hFF);
`endif

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
